player_collision: RTL and testbench

PLAYER_COLLISION -- requirements
Module: player_collision

---
 rtl/player_collision.sv | 227 ++++++++++++++++++++++
 tb/tb_player_collision.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_collision.sv
// Collision detector for a two-player trail game: a 1-bit occupancy grid records every cell a
// head has entered, and a head re-entering an occupied cell (or leaving the arena) collides.
package player_collision_pkg;
  typedef enum logic [1:0] {
    START       = 2'd0,
    GAME        = 2'd1,
    PLAYER1_WIN = 2'd2,
    PLAYER2_WIN = 2'd3
  } game_mode;
endpackage

module player_collision
  import player_collision_pkg::*;
#(
  parameter int unsigned CELL_SHIFT = 4,
  parameter int unsigned GRID_W     = 64,
  parameter int unsigned GRID_H     = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  game_mode    mode,
  input  logic        frame_tick,
  input  logic [11:0] p1_x,
  input  logic [11:0] p1_y,
  input  logic [11:0] p2_x,
  input  logic [11:0] p2_y,
  output logic        player1_collision,
  output logic        player2_collision,
  output logic        busy
);

  localparam int unsigned Depth    = GRID_W * GRID_H;
  localparam logic [12:0] XLim     = 13'(GRID_W << CELL_SHIFT);
  localparam logic [12:0] YLim     = 13'(GRID_H << CELL_SHIFT);
  localparam logic [11:0] LastAddr = 12'(Depth - 1);

  typedef enum logic [3:0] {
    StClear, StIdle, StArmed, StRd1, StChk1, StRd2, StChk2, StWr1, StWr2, StReport, StHalt
  } state_e;

  function automatic logic [11:0] cell_of(input logic [11:0] x, input logic [11:0] y);
    return {y[CELL_SHIFT+5 -: 6], x[CELL_SHIFT+5 -: 6]};
  endfunction

  function automatic logic is_oob(input logic [11:0] x, input logic [11:0] y);
    return ({1'b0, x} >= XLim) || ({1'b0, y} >= YLim);
  endfunction

  state_e      state_q, state_d;
  logic [11:0] clr_addr_q, clr_addr_d;
  logic [11:0] cell1_q, cell1_d, cell2_q, cell2_d;
  logic        oob1_q, oob1_d, oob2_q, oob2_d;
  logic [11:0] last1_q, last1_d, last2_q, last2_d;
  logic        last1_vld_q, last1_vld_d, last2_vld_q, last2_vld_d;
  logic        coll1_q, coll1_d, coll2_q, coll2_d;
  logic        dirty_q, dirty_d;

  logic        mem_q [Depth];
  logic        rd_data_q;
  logic        mem_we, mem_wdata;
  logic [11:0] mem_waddr, mem_raddr;

  logic        skip1, skip2, same_new, abort;
  state_e      abort_st;

  // A head that stays in its last written cell is neither checked nor rewritten.
  assign skip1    = !oob1_q && last1_vld_q && (last1_q == cell1_q);
  assign skip2    = !oob2_q && last2_vld_q && (last2_q == cell2_q);
  assign same_new = !oob1_q && !oob2_q && !skip1 && !skip2 && (cell1_q == cell2_q);
  assign abort    = (mode != GAME);
  assign abort_st = (mode == START) ? StClear : StHalt;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    rd_data_q <= mem_q[mem_raddr];
  end

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    cell1_d     = cell1_q;
    cell2_d     = cell2_q;
    oob1_d      = oob1_q;
    oob2_d      = oob2_q;
    last1_d     = last1_q;
    last2_d     = last2_q;
    last1_vld_d = last1_vld_q;
    last2_vld_d = last2_vld_q;
    coll1_d     = coll1_q;
    coll2_d     = coll2_q;
    dirty_d     = dirty_q;
    mem_we      = 1'b0;
    mem_wdata   = 1'b0;
    mem_waddr   = clr_addr_q;
    mem_raddr   = cell1_q;

    unique case (state_q)
      StClear: begin
        mem_we      = 1'b1;
        last1_vld_d = 1'b0;
        last2_vld_d = 1'b0;
        coll1_d     = 1'b0;
        coll2_d     = 1'b0;
        dirty_d     = 1'b0;
        if (clr_addr_q == LastAddr) begin
          clr_addr_d = '0;
          state_d    = StIdle;
        end else begin
          clr_addr_d = clr_addr_q + 12'd1;
        end
      end
      StIdle: if (mode == GAME) state_d = StArmed;
      StArmed: begin
        if (mode == GAME) begin
          if (frame_tick) begin
            cell1_d = cell_of(p1_x, p1_y);
            cell2_d = cell_of(p2_x, p2_y);
            oob1_d  = is_oob(p1_x, p1_y);
            oob2_d  = is_oob(p2_x, p2_y);
            coll1_d = 1'b0;
            coll2_d = 1'b0;
            state_d = StRd1;
          end
        end else if (mode == START) begin
          // An untouched grid is already clear, so START only drops back to idle.
          state_d = dirty_q ? StClear : StIdle;
        end else begin
          state_d = StHalt;
        end
      end
      StRd1: state_d = abort ? abort_st : StChk1;
      StChk1: begin
        if (abort) state_d = abort_st;
        else begin
          coll1_d = oob1_q || (!skip1 && rd_data_q);
          state_d = StRd2;
        end
      end
      StRd2: begin
        mem_raddr = cell2_q;
        state_d   = abort ? abort_st : StChk2;
      end
      StChk2: begin
        if (abort) state_d = abort_st;
        else begin
          coll2_d = oob2_q || (!skip2 && rd_data_q) || same_new;
          if (same_new) coll1_d = 1'b1;
          state_d = StWr1;
        end
      end
      StWr1: begin
        if (abort) state_d = abort_st;
        else begin
          if (!oob1_q && !skip1) begin
            mem_we      = 1'b1;
            mem_wdata   = 1'b1;
            mem_waddr   = cell1_q;
            last1_d     = cell1_q;
            last1_vld_d = 1'b1;
            dirty_d     = 1'b1;
          end
          state_d = StWr2;
        end
      end
      StWr2: begin
        if (abort) state_d = abort_st;
        else begin
          if (!oob2_q && !skip2) begin
            mem_we      = 1'b1;
            mem_wdata   = 1'b1;
            mem_waddr   = cell2_q;
            last2_d     = cell2_q;
            last2_vld_d = 1'b1;
            dirty_d     = 1'b1;
          end
          state_d = StReport;
        end
      end
      StReport: begin
        if (abort) state_d = abort_st;
        else state_d = (coll1_q || coll2_q) ? StHalt : StArmed;
      end
      StHalt: if (mode == START) state_d = StClear;
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StClear;
      clr_addr_q  <= '0;
      cell1_q     <= '0;
      cell2_q     <= '0;
      oob1_q      <= 1'b0;
      oob2_q      <= 1'b0;
      last1_q     <= '0;
      last2_q     <= '0;
      last1_vld_q <= 1'b0;
      last2_vld_q <= 1'b0;
      coll1_q     <= 1'b0;
      coll2_q     <= 1'b0;
      dirty_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      cell1_q     <= cell1_d;
      cell2_q     <= cell2_d;
      oob1_q      <= oob1_d;
      oob2_q      <= oob2_d;
      last1_q     <= last1_d;
      last2_q     <= last2_d;
      last1_vld_q <= last1_vld_d;
      last2_vld_q <= last2_vld_d;
      coll1_q     <= coll1_d;
      coll2_q     <= coll2_d;
      dirty_q     <= dirty_d;
    end
  end

  // Pulses are gated by mode so a mode change during REPORT suppresses them.
  assign player1_collision = (state_q == StReport) && (mode == GAME) && coll1_q;
  assign player2_collision = (state_q == StReport) && (mode == GAME) && coll2_q;
  assign busy = (state_q == StClear) || (state_q == StRd1) || (state_q == StChk1) ||
                (state_q == StRd2) || (state_q == StChk2) || (state_q == StWr1) ||
                (state_q == StWr2) || (state_q == StReport);

endmodule

// File: tb/tb_player_collision.sv
// Randomized and directed bench for player_collision; a visited-cell model predicts each frame's
// pulses and a negedge monitor checks them against the scoreboard queue.
module tb_player_collision;
  import player_collision_pkg::*;

  localparam int Cells = 64 * 48;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  game_mode    mode = START;
  logic        frame_tick = 1'b0;
  logic [11:0] p1_x = '0, p1_y = '0, p2_x = '0, p2_y = '0;
  logic        player1_collision, player2_collision, busy;

  player_collision dut (
    .clk               (clk),
    .rst               (rst),
    .mode              (mode),
    .frame_tick        (frame_tick),
    .p1_x              (p1_x),
    .p1_y              (p1_y),
    .p2_x              (p2_x),
    .p2_y              (p2_y),
    .player1_collision (player1_collision),
    .player2_collision (player2_collision),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint due;
    bit     e1;
    bit     e2;
  } exp_t;
  exp_t sbq[$];

  // Reference model: set of visited cells, each player's last written cell, halted flag.
  bit visited[Cells];
  int last1, last2;
  bit lv1, lv2, halted;

  function automatic void model_reset();
    for (int i = 0; i < Cells; i++) visited[i] = 1'b0;
    lv1 = 1'b0;
    lv2 = 1'b0;
    halted = 1'b0;
  endfunction

  function automatic bit oob(int x, int y);
    return (x >= 1024) || (y >= 768);
  endfunction

  function automatic void model_frame(int x1, int y1, int x2, int y2, output bit e1,
                                      output bit e2);
    int  c1, c2;
    bit  o1, o2, s1, s2;
    o1 = oob(x1, y1);
    o2 = oob(x2, y2);
    c1 = (y1 / 16) * 64 + (x1 / 16);
    c2 = (y2 / 16) * 64 + (x2 / 16);
    s1 = !o1 && lv1 && (last1 == c1);
    s2 = !o2 && lv2 && (last2 == c2);
    e1 = o1 ? 1'b1 : (s1 ? 1'b0 : visited[c1]);
    e2 = o2 ? 1'b1 : (s2 ? 1'b0 : visited[c2]);
    if (!o1 && !o2 && !s1 && !s2 && c1 == c2) begin
      e1 = 1'b1;
      e2 = 1'b1;
    end
    if (!o1 && !s1) begin
      visited[c1] = 1'b1;
      last1 = c1;
      lv1 = 1'b1;
    end
    if (!o2 && !s2) begin
      visited[c2] = 1'b1;
      last2 = c2;
      lv2 = 1'b1;
    end
    if (e1 || e2) halted = 1'b1;
  endfunction

  task automatic chk(string name, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: compare pulses against the entry due this cycle; any other pulse is unexpected.
  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      exp_t e;
      e = sbq.pop_front();
      n_cmp++;
      if (player1_collision !== e.e1 || player2_collision !== e.e2) begin
        n_err++;
        $display("FAIL frame_pulse: got p1=%b p2=%b, want p1=%b p2=%b (cycle %0d)",
                 player1_collision, player2_collision, e.e1, e.e2, cyc);
      end
    end else if (player1_collision !== 1'b0 || player2_collision !== 1'b0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_pulse: got p1=%b p2=%b, want none (cycle %0d)",
               player1_collision, player2_collision, cyc);
    end
  end

  task automatic wait_idle(int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("busy_timeout", 1, 0);
  endtask

  task automatic measure_clear(string name);
    int n = 0;
    while (busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
    chk(name, n, Cells);
  endtask

  task automatic tick(int x1, int y1, int x2, int y2);
    bit e1, e2;
    @(negedge clk);
    p1_x = 12'(x1);
    p1_y = 12'(y1);
    p2_x = 12'(x2);
    p2_y = 12'(y2);
    frame_tick = 1'b1;
    if (!halted) begin
      model_frame(int'(p1_x), int'(p1_y), int'(p2_x), int'(p2_y), e1, e2);
      sbq.push_back('{due: cyc + 7, e1: e1, e2: e2});
    end
    @(negedge clk);
    frame_tick = 1'b0;
    wait_idle(20);
  endtask

  task automatic new_game();
    @(negedge clk);
    mode = START;
    @(negedge clk);
    measure_clear("restart_clear_len");
    model_reset();
    mode = GAME;
    repeat (3) @(negedge clk);
  endtask

  task automatic random_game();
    int x1, y1, x2, y2;
    int r;
    new_game();
    x1 = $urandom_range(0, 1023);
    y1 = $urandom_range(0, 767);
    x2 = $urandom_range(0, 1023);
    y2 = $urandom_range(0, 767);
    for (int f = 0; f < 80 && !halted; f++) begin
      for (int p = 0; p < 2; p++) begin
        int dx = 0, dy = 0;
        r = $urandom_range(0, 19);
        if (r >= 3 && r <= 17) begin
          if ($urandom_range(0, 1) == 1) dx = ($urandom_range(0, 1) == 1) ? 16 : -16;
          else dy = ($urandom_range(0, 1) == 1) ? 16 : -16;
        end
        if (p == 0) begin
          x1 = (r >= 18) ? $urandom_range(0, 1100) : (x1 + dx) & 12'hFFF;
          y1 = (r >= 18) ? $urandom_range(0, 800) : (y1 + dy) & 12'hFFF;
        end else begin
          x2 = (r >= 18) ? $urandom_range(0, 1100) : (x2 + dx) & 12'hFFF;
          y2 = (r >= 18) ? $urandom_range(0, 800) : (y2 + dy) & 12'hFFF;
        end
      end
      tick(x1, y1, x2, y2);
    end
    tick(x1, y1, x2, y2);  // halted frames must stay silent
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 1);
    chk("reset_p1", int'(player1_collision), 0);
    chk("reset_p2", int'(player2_collision), 0);
    rst = 1'b1;
    measure_clear("initial_clear_len");

    // START while armed on a clean grid must not start a clear.
    mode = GAME;
    repeat (3) @(negedge clk);
    mode = START;
    repeat (4) @(negedge clk);
    chk("start_clean_no_clear", int'(busy), 0);
    mode = GAME;
    repeat (3) @(negedge clk);

    tick(100, 100, 500, 500);
    tick(116, 100, 500, 500);
    tick(100, 100, 500, 500);  // p1 revisits its trail

    new_game();
    for (int i = 0; i < 10; i++) tick(100, 100, 500, 500);
    tick(200, 200, 200, 200);  // both enter one new cell

    new_game();
    tick(100, 100, 1024, 100);
    for (int i = 0; i < 3; i++) tick(120, 100, 500, 500);

    // Abort mid-evaluation via START: no pulse, full clear, grid really empty afterwards.
    new_game();
    tick(300, 300, 600, 600);
    @(negedge clk);
    p1_x = 12'd316;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    mode = START;
    @(negedge clk);
    measure_clear("abort_clear_len");
    model_reset();
    mode = GAME;
    repeat (3) @(negedge clk);
    tick(300, 300, 600, 600);

    // Reset during evaluation cancels the pending pulse.
    tick(300, 316, 600, 600);
    @(negedge clk);
    p1_x = 12'd300;
    p1_y = 12'd300;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("midreset_busy", int'(busy), 1);
    rst = 1'b1;
    measure_clear("midreset_clear_len");
    model_reset();
    mode = GAME;
    repeat (3) @(negedge clk);
    tick(300, 300, 600, 600);

    for (int g = 0; g < 4; g++) random_game();

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
